// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX engine and the future RX engine.
//   uart_state_t      : 2-bit frame state (IDLE, START, DATA, STOP)
//   symbol_edge_time  : clock cycles per UART symbol for a clk/baud pair
//   cnt_width         : width of a counter that spans 0..n-1
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Symbol-period counter. Counts 0..SYMBOL_EDGE_TIME-1 while enabled and wraps;
// tick is high during the last cycle of each symbol, so the consumer advances
// on the wrap edge.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   enable in  count when high
//   clear  in  force count to 0 (takes priority over enable)
//   tick   out high when enabled and count is at its final value
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned SYMBOL_EDGE_TIME = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = cnt_width(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] LAST = CW'(SYMBOL_EDGE_TIME - 1);

  logic [CW-1:0] clk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
    end else if (clear) begin
      clk_cnt <= '0;
    end else if (enable) begin
      if (clk_cnt == LAST) clk_cnt <= '0;
      else                 clk_cnt <= clk_cnt + 1'b1;
    end
  end

  assign tick = enable && (clk_cnt == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter. Takes a byte over a valid/ready handshake and shifts
// it out as start(0), 8 data bits LSB first, stop(1). Line idles high.
//   clk            in   clock, all state on rising edge
//   rst_n          in   asynchronous active-low reset (aborts any frame)
//   data_in[7:0]   in   byte to send, sampled on the accept edge only
//   data_in_valid  in   producer has a byte
//   data_in_ready  out  engine idle and able to accept (registered)
//   serial_out     out  UART line (registered)
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int unsigned SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);

  uart_state_t state, state_nxt;
  logic [7:0]  shift_q, shift_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        serial_q, serial_nxt;
  logic        ready_q, ready_nxt;
  logic        accept;
  logic        tick;

  assign accept = data_in_valid && ready_q;

  // Cleared on accept so the start bit always lasts a full symbol.
  uart_baud_counter #(
    .SYMBOL_EDGE_TIME(SET)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state != IDLE),
    .clear  (accept),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      state    <= state_nxt;
      shift_q  <= shift_nxt;
      bit_cnt  <= bit_cnt_nxt;
      serial_q <= serial_nxt;
      ready_q  <= ready_nxt;
    end
  end

  // Outputs are registered: the line value for the coming symbol is chosen
  // here from the next state, so it appears on the same edge the state moves.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt;
    serial_nxt  = serial_q;
    ready_nxt   = ready_q;
    unique case (state)
      IDLE: begin
        serial_nxt = 1'b1;
        ready_nxt  = 1'b1;
        if (accept) begin
          state_nxt   = START;
          shift_nxt   = data_in;
          bit_cnt_nxt = '0;
          serial_nxt  = 1'b0;
          ready_nxt   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_nxt  = DATA;
          serial_nxt = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt  = STOP;
            serial_nxt = 1'b1;
          end else begin
            serial_nxt = shift_q[bit_cnt_nxt];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt  = IDLE;
          serial_nxt = 1'b1;
          ready_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        serial_nxt = 1'b1;
        ready_nxt  = 1'b1;
      end
    endcase
  end

  assign serial_out    = serial_q;
  assign data_in_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  localparam int unsigned CPS = 10;  // cycles per symbol at 1000 Hz / 100 baud

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [7:0]  decoded[$];
  int unsigned frame_err = 0;
  int unsigned x_err = 0;

  uart_tx_engine #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .serial_out    (serial_out)
  );

  always #5 clk = ~clk;

  // Independent UART receiver: detects the falling start edge, samples each
  // symbol at its middle and checks start and stop levels.
  initial begin : rx_model
    bit          busy;
    int unsigned phase;
    logic [7:0]  b;
    busy  = 0;
    phase = 0;
    b     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
      end else begin
        if ($isunknown(serial_out) || $isunknown(data_in_ready)) x_err++;
        if (!busy) begin
          if (serial_out === 1'b0) begin
            busy  = 1;
            phase = 0;
          end
        end else begin
          phase++;
          if (phase % CPS == CPS / 2) begin
            if (phase / CPS == 0) begin
              if (serial_out !== 1'b0) frame_err++;
            end else if (phase / CPS <= 8) begin
              b[phase / CPS - 1] = serial_out;
            end else begin
              if (serial_out !== 1'b1) frame_err++;
              decoded.push_back(b);
              busy = 0;
            end
          end
        end
      end
    end
  end

  // Waits (bounded) for ready at a falling edge, presents the byte, and
  // returns 1 ns after the accepting rising edge with valid dropped.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (data_in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL send_timeout byte=%02h ready=%b required 1", b, data_in_ready);
    end
    data_in       = b;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1 data_in_valid = 1'b0;
  endtask

  task automatic wait_decoded(input int unsigned count, input int unsigned bound);
    int unsigned n;
    n = 0;
    while (decoded.size() < count && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (decoded.size() < count) begin
      total++; bad++;
      $display("FAIL decode_timeout got=%0d required=%0d", decoded.size(), count);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    data_in       = 8'h5A;
    data_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (serial_out !== 1'b1) begin
      bad++; $display("FAIL reset_serial got=%b required=1", serial_out);
    end
    total++;
    if (data_in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b required=1", data_in_ready);
    end
    data_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    total++;
    if (decoded.size() != 0) begin
      bad++; $display("FAIL reset_no_frame got=%0d frames required=0", decoded.size());
    end
    total++;
    if (serial_out !== 1'b1) begin
      bad++; $display("FAIL reset_idle_line got=%b required=1", serial_out);
    end
  endtask

  task automatic test_single();
    logic [7:0]  byte_v;
    logic        exp_line;
    int unsigned sym;
    int unsigned base;
    byte_v = 8'hA5;
    base   = decoded.size();
    send_byte(byte_v);
    for (int k = 0; k < 10 * CPS; k++) begin
      @(negedge clk);
      sym = k / CPS;
      if (sym == 0)      exp_line = 1'b0;
      else if (sym <= 8) exp_line = byte_v[sym - 1];
      else               exp_line = 1'b1;
      total++;
      if (serial_out !== exp_line) begin
        bad++; $display("FAIL single_line cycle=%0d got=%b required=%b", k, serial_out, exp_line);
      end
      total++;
      if (data_in_ready !== 1'b0) begin
        bad++; $display("FAIL single_ready_low cycle=%0d got=%b required=0", k, data_in_ready);
      end
    end
    @(negedge clk);
    total++;
    if (data_in_ready !== 1'b1) begin
      bad++; $display("FAIL single_ready_return got=%b required=1", data_in_ready);
    end
    wait_decoded(base + 1, 50);
    total++;
    if (decoded.size() != base + 1 || decoded[base] !== byte_v) begin
      bad++; $display("FAIL single_decode got=%02h required=%02h", decoded[decoded.size()-1], byte_v);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned base;
    int unsigned ferr0;
    base  = decoded.size();
    ferr0 = frame_err;
    send_byte(8'h00);
    data_in       = 8'hFF;
    data_in_valid = 1'b1;
    for (int k = 0; k <= 10 * CPS + 1; k++) begin
      @(negedge clk);
      if (k == 10 * CPS - 1) begin
        total++;
        if (serial_out !== 1'b1) begin
          bad++; $display("FAIL b2b_stop got=%b required=1", serial_out);
        end
      end
      if (k == 10 * CPS) begin
        total++;
        if (serial_out !== 1'b1 || data_in_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_idle_gap got line=%b ready=%b required 1,1", serial_out, data_in_ready);
        end
      end
      if (k == 10 * CPS + 1) begin
        total++;
        if (serial_out !== 1'b0 || data_in_ready !== 1'b0) begin
          bad++; $display("FAIL b2b_second_start got line=%b ready=%b required 0,0", serial_out, data_in_ready);
        end
        data_in_valid = 1'b0;
      end
    end
    wait_decoded(base + 2, 150);
    total++;
    if (decoded.size() != base + 2 || decoded[base] !== 8'h00 || decoded[base+1] !== 8'hFF) begin
      bad++; $display("FAIL b2b_decode got_count=%0d required 2 frames 00,FF", decoded.size() - base);
    end
    total++;
    if (frame_err != ferr0) begin
      bad++; $display("FAIL b2b_framing got=%0d errors required=0", frame_err - ferr0);
    end
  endtask

  task automatic test_ignore_busy();
    int unsigned base;
    int unsigned n;
    int unsigned idle_bad;
    base = decoded.size();
    send_byte(8'hC3);
    repeat (35) @(negedge clk);
    data_in       = 8'h3C;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    n = 0;
    while (data_in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (data_in_ready !== 1'b1) begin
      bad++; $display("FAIL busy_ready_timeout got=%b required=1", data_in_ready);
    end
    idle_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || data_in_ready !== 1'b1) idle_bad++;
    end
    total++;
    if (idle_bad != 0) begin
      bad++; $display("FAIL busy_extra_frame got=%0d non-idle cycles required=0", idle_bad);
    end
    total++;
    if (decoded.size() != base + 1 || decoded[decoded.size()-1] !== 8'hC3) begin
      bad++; $display("FAIL busy_decode got_count=%0d last=%02h required 1 frame C3", decoded.size() - base, decoded[decoded.size()-1]);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned base;
    int unsigned ferr0;
    base  = decoded.size();
    send_byte(8'h0F);
    repeat (55) @(negedge clk);  // cycle 54: middle of data bit 4 (value 0)
    total++;
    if (serial_out !== 1'b0) begin
      bad++; $display("FAIL midrst_bit4 got=%b required=0", serial_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (serial_out !== 1'b1) begin
      bad++; $display("FAIL midrst_line_async got=%b required=1", serial_out);
    end
    total++;
    if (data_in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_ready_async got=%b required=1", data_in_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (data_in_ready !== 1'b1 || serial_out !== 1'b1) begin
      bad++; $display("FAIL midrst_after_release got ready=%b line=%b required 1,1", data_in_ready, serial_out);
    end
    ferr0 = frame_err;
    send_byte(8'h55);
    wait_decoded(base + 1, 150);
    total++;
    if (decoded.size() != base + 1 || decoded[base] !== 8'h55 || frame_err != ferr0) begin
      bad++; $display("FAIL midrst_next_byte got_count=%0d last=%02h ferr=%0d required 1 frame 55 no error", decoded.size() - base, decoded[decoded.size()-1], frame_err - ferr0);
    end
  endtask

  task automatic test_random();
    logic [7:0]  sent[$];
    logic [7:0]  b;
    int unsigned base;
    int unsigned ferr0;
    int unsigned mism;
    base  = decoded.size();
    ferr0 = frame_err;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      b = 8'($urandom);
      sent.push_back(b);
      send_byte(b);
    end
    wait_decoded(base + 200, 300);
    mism = 0;
    for (int i = 0; i < 200; i++) begin
      if (base + i >= decoded.size() || decoded[base + i] !== sent[i]) mism++;
    end
    total++;
    if (mism != 0) begin
      bad++; $display("FAIL random_stream got=%0d mismatching bytes required=0", mism);
    end
    total++;
    if (decoded.size() != base + 200) begin
      bad++; $display("FAIL random_count got=%0d required=200", decoded.size() - base);
    end
    total++;
    if (frame_err != ferr0) begin
      bad++; $display("FAIL random_framing got=%0d errors required=0", frame_err - ferr0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    total++;
    if (x_err != 0) begin
      bad++; $display("FAIL x_on_outputs got=%0d cycles required=0", x_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
